// File: rtl/demux64_frame_sequencer.sv
// demux64_frame_sequencer
// Drives the 6-bit select of a 64-way single-bit demultiplexer. Serial bits
// arrive over in_valid/in_ready. The select walks the channels enabled in the
// mask from lowest to highest. Each accepted bit is written into a 64-bit
// frame. The frame is then held until frame_ack, after which the sequencer
// rearms automatically.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   cfg_load, cfg_mask  load a channel mask and (re)start a frame
//   cfg_err             one-cycle pulse: cfg_load accepted with an all-zero mask
//   in_bit, in_valid    serial input; in_ready is the accept handshake
//   sel                 current channel (demux select)
//   strobe              one-hot write enable at sel on accept cycles
//   bit_cnt             bits accepted in the current frame (0..64)
//   frame, frame_valid  assembled frame, held until frame_ack
//   busy                sequencer not idle
module demux64_frame_sequencer #(
    parameter int SEL_W = 6,
    parameter int N_CH  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load,
    input  logic [N_CH-1:0]  cfg_mask,
    output logic             cfg_err,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [SEL_W-1:0] sel,
    output logic [N_CH-1:0]  strobe,
    output logic [SEL_W:0]   bit_cnt,
    output logic [N_CH-1:0]  frame,
    output logic             frame_valid,
    input  logic             frame_ack,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [N_CH-1:0] mask;

    // Index of the lowest set bit (0 when none is set).
    function automatic logic [SEL_W-1:0] lowest(input logic [N_CH-1:0] m);
        logic [SEL_W-1:0] lo;
        lo = '0;
        for (int i = N_CH-1; i >= 0; i--)
            if (m[i]) lo = SEL_W'(i);
        return lo;
    endfunction

    // Enabled channels strictly above sel. The extra shift pushes bit 63 out,
    // so when sel is 63 nothing remains and the search never wraps.
    logic [N_CH-1:0]  upper;
    logic             has_next;
    logic [SEL_W-1:0] nxt;
    logic             accept;

    assign upper    = mask & (({N_CH{1'b1}} << sel) << 1);
    assign has_next = |upper;
    assign nxt      = lowest(upper);

    // cfg_load takes priority over data, so no bit is accepted on a load cycle.
    assign in_ready = (state == RUN) && !cfg_load;
    assign accept   = in_valid && in_ready;
    assign strobe   = accept ? (N_CH'(1) << sel) : '0;
    assign busy     = (state != IDLE);

    // A restart request comes from cfg_load in IDLE/RUN, or from frame_ack
    // in DONE. In DONE, a simultaneous cfg_load replaces the held mask.
    logic            restart;
    logic [N_CH-1:0] new_mask;

    always_comb begin
        restart  = 1'b0;
        new_mask = cfg_mask;
        case (state)
            IDLE, RUN: restart = cfg_load;
            DONE: begin
                restart  = frame_ack;
                new_mask = cfg_load ? cfg_mask : mask;
            end
            default: restart = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mask        <= '0;
            sel         <= '0;
            bit_cnt     <= '0;
            frame       <= '0;
            frame_valid <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            if (restart) begin
                // Any restart discards the current frame, including an
                // aborted one that falls back to IDLE.
                frame       <= '0;
                bit_cnt     <= '0;
                frame_valid <= 1'b0;
                if (|new_mask) begin
                    mask  <= new_mask;
                    sel   <= lowest(new_mask);
                    state <= RUN;
                end else begin
                    cfg_err <= 1'b1;
                    state   <= IDLE;
                end
            end else if (accept) begin
                frame[sel] <= in_bit;
                bit_cnt    <= bit_cnt + 1'b1;
                if (has_next) begin
                    sel <= nxt;
                end else begin
                    state       <= DONE;
                    frame_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux64_frame_sequencer.sv
module tb_demux64_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_load;
    logic [63:0] cfg_mask;
    logic        cfg_err;
    logic        in_bit;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  sel;
    logic [63:0] strobe;
    logic [6:0]  bit_cnt;
    logic [63:0] frame;
    logic        frame_valid;
    logic        frame_ack;
    logic        busy;

    demux64_frame_sequencer dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_mask(cfg_mask),
        .cfg_err(cfg_err), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(in_ready), .sel(sel), .strobe(strobe), .bit_cnt(bit_cnt),
        .frame(frame), .frame_valid(frame_valid), .frame_ack(frame_ack),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] frm;
        int          cnt;
    } frame_exp_t;

    int         acc_q[$];
    frame_exp_t frame_q[$];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [63:0] f, input int c);
        frame_exp_t e;
        e.frm = f;
        e.cnt = c;
        frame_q.push_back(e);
    endtask

    task automatic chk_reset_vals();
        chk("rst_sel", 64'(sel), 64'd0);
        chk("rst_bit_cnt", 64'(bit_cnt), 64'd0);
        chk("rst_frame", frame, 64'd0);
        chk("rst_frame_valid", 64'(frame_valid), 64'd0);
        chk("rst_cfg_err", 64'(cfg_err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_strobe", strobe, 64'd0);
    endtask

    // Monitor: checks every accept against the expected select and every
    // rising frame_valid against the expected frame.
    logic fv_q = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            fv_q <= 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                if (acc_q.size() == 0) begin
                    chk("unexpected_accept", 64'(sel), 64'hFFFF);
                end else begin
                    int e;
                    e = acc_q.pop_front();
                    chk("acc_sel", 64'(sel), 64'(e));
                    chk("acc_strobe", strobe, 64'd1 << e);
                end
            end else begin
                chk("idle_strobe", strobe, 64'd0);
            end
            if (frame_valid && !fv_q) begin
                if (frame_q.size() == 0) begin
                    chk("unexpected_frame", frame, 64'hDEAD);
                end else begin
                    frame_exp_t f;
                    f = frame_q.pop_front();
                    chk("frame", frame, f.frm);
                    chk("frame_bit_cnt", 64'(bit_cnt), 64'(f.cnt));
                end
            end
            fv_q <= frame_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq2[3];
        rst = 1'b1; cfg_load = 1'b0; cfg_mask = '0; in_bit = 1'b0;
        in_valid = 1'b0; frame_ack = 1'b0;
        #12;
        chk_reset_vals();
        tick();
        rst = 1'b0;
        tick();

        // Full mask, alternating 1,0 from channel 0.
        cfg_load = 1'b1; cfg_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        cfg_load = 1'b0;
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_sel0", 64'(sel), 64'd0);
        push_frame(64'h5555_5555_5555_5555, 64);
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1;
            in_bit   = (i % 2 == 0);
            acc_q.push_back(i);
            if (i == 63) chk("t1_fv_before_last", 64'(frame_valid), 64'd0);
            tick();
        end
        in_valid = 1'b0;
        chk("t1_fv", 64'(frame_valid), 64'd1);
        chk("t1_bit_cnt", 64'(bit_cnt), 64'd64);
        chk("t1_sel63", 64'(sel), 64'd63);

        // DONE holds against in_valid and lone cfg_load pulses.
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_bit = 1'b1;
            cfg_load = (k % 2 == 0); cfg_mask = 64'h1;
            #1;
            chk("done_in_ready", 64'(in_ready), 64'd0);
            chk("done_strobe", strobe, 64'd0);
            tick();
            chk("done_frame", frame, 64'h5555_5555_5555_5555);
            chk("done_sel", 64'(sel), 64'd63);
            chk("done_fv", 64'(frame_valid), 64'd1);
        end
        cfg_load = 1'b0; in_valid = 1'b0;
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        chk("ack_sel", 64'(sel), 64'd0);
        chk("ack_frame", frame, 64'd0);
        chk("ack_bit_cnt", 64'(bit_cnt), 64'd0);
        chk("ack_fv", 64'(frame_valid), 64'd0);
        chk("ack_busy", 64'(busy), 64'd1);

        // Sparse mask with bit 63: sel 0,4,63 and no wrap.
        cfg_load = 1'b1; cfg_mask = 64'h8000_0000_0000_0011;
        tick();
        cfg_load = 1'b0;
        chk("t2_sel0", 64'(sel), 64'd0);
        push_frame(64'h8000_0000_0000_0011, 3);
        seq2 = '{0, 4, 63};
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_bit = 1'b1;
            acc_q.push_back(seq2[i]);
            tick();
        end
        in_valid = 1'b0;
        chk("t2_fv", 64'(frame_valid), 64'd1);
        tick();
        chk("t2_nowrap", 64'(sel), 64'd63);
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        chk("t2_ack_sel", 64'(sel), 64'd0);
        chk("t2_ack_frame", frame, 64'd0);
        chk("t2_ack_busy", 64'(busy), 64'd1);

        // Abort in RUN at bit_cnt=3.
        cfg_load = 1'b1; cfg_mask = 64'hFF;
        tick();
        cfg_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_bit = (i != 1);
            acc_q.push_back(i);
            tick();
        end
        chk("ab_bit_cnt", 64'(bit_cnt), 64'd3);
        chk("ab_sel", 64'(sel), 64'd3);
        cfg_load = 1'b1; cfg_mask = 64'h100; in_valid = 1'b1; in_bit = 1'b1;
        #1;
        chk("ab_in_ready", 64'(in_ready), 64'd0);
        chk("ab_strobe", strobe, 64'd0);
        tick();
        cfg_load = 1'b0;
        chk("ab_new_sel", 64'(sel), 64'd8);
        chk("ab_new_cnt", 64'(bit_cnt), 64'd0);
        chk("ab_new_frame", frame, 64'd0);

        // Single-bit mask completes on the first accept.
        push_frame(64'h100, 1);
        acc_q.push_back(8);
        tick();
        in_valid = 1'b0;
        chk("sb_fv", 64'(frame_valid), 64'd1);

        // Zero mask with frame_ack in DONE -> IDLE with cfg_err.
        cfg_load = 1'b1; cfg_mask = '0; frame_ack = 1'b1;
        tick();
        cfg_load = 1'b0; frame_ack = 1'b0;
        chk("err_done_pulse", 64'(cfg_err), 64'd1);
        chk("err_done_busy", 64'(busy), 64'd0);
        chk("err_done_fv", 64'(frame_valid), 64'd0);
        tick();
        chk("err_done_clear", 64'(cfg_err), 64'd0);

        // Zero mask in IDLE.
        cfg_load = 1'b1; cfg_mask = '0;
        tick();
        cfg_load = 1'b0;
        chk("err_idle_pulse", 64'(cfg_err), 64'd1);
        chk("err_idle_busy", 64'(busy), 64'd0);
        tick();
        chk("err_idle_clear", 64'(cfg_err), 64'd0);

        // Zero mask in RUN.
        cfg_load = 1'b1; cfg_mask = 64'hF0;
        tick();
        chk("err_run_busy1", 64'(busy), 64'd1);
        chk("err_run_sel", 64'(sel), 64'd4);
        cfg_mask = '0;
        tick();
        cfg_load = 1'b0;
        chk("err_run_pulse", 64'(cfg_err), 64'd1);
        chk("err_run_busy", 64'(busy), 64'd0);
        tick();
        chk("err_run_clear", 64'(cfg_err), 64'd0);

        // Gaps in in_valid, then reset mid-frame at sel=5, bit_cnt=5.
        cfg_load = 1'b1; cfg_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        cfg_load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_bit = 1'b1;
            acc_q.push_back(i);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("gap_sel", 64'(sel), 64'd2);
            chk("gap_cnt", 64'(bit_cnt), 64'd2);
        end
        for (int i = 2; i < 5; i++) begin
            in_valid = 1'b1; in_bit = 1'b0;
            acc_q.push_back(i);
            tick();
        end
        in_valid = 1'b0;
        chk("mid_sel", 64'(sel), 64'd5);
        chk("mid_cnt", 64'(bit_cnt), 64'd5);
        rst = 1'b1;
        #2;
        chk_reset_vals();
        tick();
        rst = 1'b0;
        tick();
        cfg_load = 1'b1; cfg_mask = 64'h3;
        tick();
        cfg_load = 1'b0;
        push_frame(64'h2, 2);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_bit = (i == 1);
            acc_q.push_back(i);
            tick();
        end
        in_valid = 1'b0;
        chk("post_rst_fv", 64'(frame_valid), 64'd1);
        tick();
        tick();
        chk("acc_q_empty", 64'(acc_q.size()), 64'd0);
        chk("frame_q_empty", 64'(frame_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux64_frame_sequencer.md
Name: demux64_frame_sequencer

Overview:
- Sequencer that drives the select of the 64-way single-bit demultiplexer.
- Accepts a serial bit stream over a valid/ready handshake and steps the 6-bit select through the channels enabled in a 64-bit mask, lowest to highest.
- Produces the per-channel write strobe and assembles the routed bits into a 64-bit frame, which is held until the consumer acknowledges it.
- Sits between a serial source and the 64 per-channel sinks.

Parameters:
- SEL_W, 6, select width; fixed at 6 for this block.
- N_CH, 64, channel count; equals 2**SEL_W; fixed.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous reset, active-high.
- cfg_load  in  1  load cfg_mask and (re)start a frame.
- cfg_mask  in  64  channel enable mask; bit i enables channel i.
- cfg_err  out  1  one-cycle pulse when cfg_load is accepted with an all-zero mask.
- in_bit  in  1  serial data bit.
- in_valid  in  1  in_bit valid.
- in_ready  out  1  bit accepted when in_valid && in_ready.
- sel  out  6  current channel; drives the demultiplexer select.
- strobe  out  64  one-hot write enable: bit sel is set on an accept cycle; otherwise all zero.
- bit_cnt  out  7  number of bits accepted in the current frame (0..64).
- frame  out  64  assembled frame; bit i is the value routed to channel i.
- frame_valid  out  1  frame complete and stable.
- frame_ack  in  1  consumer takes the frame.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst=1): state IDLE; mask=0, sel=0, bit_cnt=0, frame=0, frame_valid=0, cfg_err=0, busy=0. in_ready and strobe are 0.
- States: IDLE, RUN, DONE.
- Definition: lowest(m) is the index of the lowest set bit of m. next(s) is the lowest set mask bit strictly above s; the search does not wrap.
- IDLE:
  - in_ready=0.
  - cfg_load with mask≠0: next cycle mask=cfg_mask, frame=0, bit_cnt=0, sel=lowest(cfg_mask), state RUN.
  - cfg_load with mask=0: cfg_err=1 for the next cycle; stay IDLE.
- RUN:
  - in_ready = !cfg_load (combinational).
  - On accept: frame[sel]<=in_bit, bit_cnt+=1, strobe=1<<sel in the same cycle (combinational).
  - If next(sel) exists: sel<=next(sel).
  - Otherwise sel holds and state becomes DONE; frame_valid=1 on the cycle after the last accept, with the last bit included.
  - cfg_load in RUN aborts the partial frame and behaves as cfg_load in IDLE: with a zero mask it returns to IDLE and pulses cfg_err. No bit is accepted that cycle.
- DONE:
  - in_ready=0, strobe=0; frame and sel are stable.
  - frame_ack: next cycle frame_valid=0, frame=0, bit_cnt=0, sel=lowest(mask), state RUN (auto-rearm with the same mask).
  - cfg_load without frame_ack is ignored.
  - cfg_load together with frame_ack rearms with cfg_mask; a zero cfg_mask goes to IDLE with cfg_err.
- frame bits for disabled channels are always 0.
- A frame completes after exactly popcount(mask) accepts.
- Single-bit mask: the first accept completes the frame, and frame_valid rises the next cycle.
- Mask bit 63 set: after channel 63, state goes to DONE; sel never wraps to 0.
- in_valid may drop at any time; sel and bit_cnt hold while no accept occurs.
- Throughput: one bit per cycle in RUN. A dead cycle occurs between frame_ack and the first accept of the next frame (DONE→RUN transition).
- Reset asserted mid-frame: all outputs reach their reset values immediately, without waiting for a clock edge.

Test Plan:
- Reset, then cfg_load with mask=64'hFFFF_FFFF_FFFF_FFFF and stream bits alternating 1,0 for 64 cycles -> sel steps 0..63; strobe one-hot at sel each cycle; frame_valid rises the cycle after the 64th accept; frame=64'h5555_5555_5555_5555; bit_cnt=64.
- mask=64'h8000_0000_0000_0011, bits 1,1,1 -> sel 0,4,63; frame=64'h8000_0000_0000_0011; no wrap after 63; frame_ack -> sel=0, frame=0, RUN.
- cfg_load with mask=0 in IDLE and again in RUN -> cfg_err one-cycle pulse each time; state IDLE; busy=0.
- In RUN with bit_cnt=3, assert cfg_load and in_valid together with new mask 64'h0000_0000_0000_0100 -> bit not accepted (in_ready=0, strobe=0); next cycle sel=8, bit_cnt=0, frame=0.
- In DONE, hold frame_ack=0 for 5 cycles with in_valid=1 and cfg_load pulses -> frame, sel and frame_valid unchanged; in_ready=0.
- Assert rst mid-frame (sel=5, bit_cnt=5) -> all outputs reach reset values before the next clk edge; a new cfg_load then restarts normally.
